// File: rtl/lock_pkg.sv
// Shared definitions for the password-lock controller.
//   - lock_state_e : state encodings WAIT..SETKEY (3 bits)
//   - BTN_*        : bit positions of the buttons in the internal button vector
//   - DEFAULT_KEY  : key loaded at reset
//   - max3         : helper used to size the millisecond timer
package lock_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_INPUT  = 3'd1,
        ST_UNLOCK = 3'd2,
        ST_ERROR  = 3'd3,
        ST_ALARM  = 3'd4,
        ST_SETKEY = 3'd5
    } lock_state_e;

    localparam int BTN_ADMIN     = 0;
    localparam int BTN_OK        = 1;
    localparam int BTN_BACKSPACE = 2;

    localparam logic [15:0] DEFAULT_KEY = 16'h1234;

    // Largest of three values; sizes the timer for the longest timed state.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/lock_ms_timer.sv
// Loadable millisecond down-counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load 'value' into the counter (wins over tick)
//   value     : count to load; loading zero parks the timer
//   tick      : 1 ms pulse, decrements a non-zero count
//   expired   : one-cycle pulse on the tick that takes the count from 1 to 0
module lock_ms_timer #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         tick,
    output logic         expired
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] cnt_r;

    // Countdown register: load has priority so a tick on the load cycle is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= value;
        end else if (tick && (cnt_r != ZERO)) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry coincides with the register reaching zero on this edge.
    always_comb begin
        expired = tick && !load && (cnt_r == ONE);
    end

endmodule

// File: rtl/lock_ctrl.sv
// Password-lock sequencing controller.
// Consumes pre-debounced single-cycle pulses and a 1 ms tick; runs code entry,
// key comparison, error counting, alarm lockout, unlock hold and key change.
// Ports:
//   CLK, RESET         : clock, asynchronous active-high reset
//   TICK_1MS           : 1 ms pulse
//   DIG_VALID, DIG     : digit pulse and value (values above 9 ignored)
//   BTN_OK/BKSP/ADMIN  : button pulses (priority OK > BKSP > digit > ADMIN)
//   STATE              : current state encoding
//   CODE_BUF, DIG_CNT  : entered digits (newest in [3:0]) and their count
//   ERR_CNT            : consecutive wrong attempts
//   UNLOCK, ALARM      : high while in the respective state
// All outputs are registered.
module lock_ctrl #(
    parameter int NDIG      = 4,
    parameter int MAX_ERR   = 3,
    parameter int UNLOCK_MS = 5000,
    parameter int ERROR_MS  = 1000,
    parameter int ALARM_MS  = 10000,
    parameter logic [4*NDIG-1:0] DEFAULT_KEY = lock_pkg::DEFAULT_KEY
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TICK_1MS,
    input  logic              DIG_VALID,
    input  logic [3:0]        DIG,
    input  logic              BTN_OK,
    input  logic              BTN_BKSP,
    input  logic              BTN_ADMIN,
    output logic [2:0]        STATE,
    output logic [4*NDIG-1:0] CODE_BUF,
    output logic [2:0]        DIG_CNT,
    output logic [1:0]        ERR_CNT,
    output logic              UNLOCK,
    output logic              ALARM
);

    import lock_pkg::*;

    localparam int TMAX = max3(UNLOCK_MS, ERROR_MS, ALARM_MS);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = 4 * NDIG;

    localparam logic [BW-1:0] BUF_ZERO = {BW{1'b0}};
    localparam logic [2:0]    CNT_FULL = 3'(NDIG);
    localparam logic [2:0]    ERR_MAX  = 3'(MAX_ERR);

    lock_state_e   state_r, state_s;
    logic [BW-1:0] buf_r, buf_s;
    logic [2:0]    cnt_r, cnt_s;
    logic [1:0]    err_r, err_s;
    logic [BW-1:0] key_r, key_s;
    logic          unlock_r, alarm_r;

    logic [2:0]    btn_s;
    logic          dig_s;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_value_s;
    logic          tmr_expired_s;
    logic [2:0]    err_inc_s;

    lock_ms_timer #(
        .W (TW)
    ) u_timer (
        .clk     (CLK),
        .rst     (RESET),
        .load    (tmr_load_s),
        .value   (tmr_value_s),
        .tick    (TICK_1MS),
        .expired (tmr_expired_s)
    );

    // Resolve same-cycle pulses to a single winning event.
    always_comb begin
        btn_s                          = 3'b000;
        btn_s[lock_pkg::BTN_OK]        = BTN_OK;
        btn_s[lock_pkg::BTN_BACKSPACE] = BTN_BKSP & ~BTN_OK;
        dig_s                          = DIG_VALID & ~BTN_OK & ~BTN_BKSP & (DIG <= 4'd9);
        // An out-of-range digit still occupies its priority slot and blocks ADMIN.
        btn_s[lock_pkg::BTN_ADMIN]     = BTN_ADMIN & ~BTN_OK & ~BTN_BKSP & ~DIG_VALID;
        err_inc_s                      = {1'b0, err_r} + 3'd1;
    end

    // Next-state, buffer, key, error counter and timer control.
    always_comb begin
        state_s     = state_r;
        buf_s       = buf_r;
        cnt_s       = cnt_r;
        err_s       = err_r;
        key_s       = key_r;
        tmr_load_s  = 1'b0;
        tmr_value_s = {TW{1'b0}};
        case (state_r)
            ST_WAIT: begin
                if (dig_s) begin
                    buf_s   = {buf_r[BW-5:0], DIG};
                    cnt_s   = cnt_r + 3'd1;
                    state_s = ST_INPUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_INPUT, ST_SETKEY: begin
                if (btn_s[lock_pkg::BTN_OK]) begin
                    if (cnt_r != CNT_FULL) begin
                        state_s = state_r;
                    end else if (state_r == ST_SETKEY) begin
                        key_s   = buf_r;
                        buf_s   = BUF_ZERO;
                        cnt_s   = 3'd0;
                        state_s = ST_WAIT;
                    end else begin
                        buf_s      = BUF_ZERO;
                        cnt_s      = 3'd0;
                        tmr_load_s = 1'b1;
                        if (buf_r == key_r) begin
                            err_s       = 2'd0;
                            state_s     = ST_UNLOCK;
                            tmr_value_s = TW'(UNLOCK_MS);
                        end else if (err_inc_s >= ERR_MAX) begin
                            err_s       = ERR_MAX[1:0];
                            state_s     = ST_ALARM;
                            tmr_value_s = TW'(ALARM_MS);
                        end else begin
                            err_s       = err_inc_s[1:0];
                            state_s     = ST_ERROR;
                            tmr_value_s = TW'(ERROR_MS);
                        end
                    end
                end else if (btn_s[lock_pkg::BTN_BACKSPACE]) begin
                    // An empty INPUT entry stays in INPUT.
                    if (cnt_r != 3'd0) begin
                        buf_s = {4'h0, buf_r[BW-1:4]};
                        cnt_s = cnt_r - 3'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (dig_s) begin
                    if (cnt_r < CNT_FULL) begin
                        buf_s = {buf_r[BW-5:0], DIG};
                        cnt_s = cnt_r + 3'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (btn_s[lock_pkg::BTN_ADMIN] && (state_r == ST_SETKEY)) begin
                    buf_s   = BUF_ZERO;
                    cnt_s   = 3'd0;
                    state_s = ST_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_UNLOCK: begin
                if (tmr_expired_s) begin
                    state_s = ST_WAIT;
                end else if (btn_s[lock_pkg::BTN_ADMIN]) begin
                    // Loading zero parks the timer for the whole SETKEY session.
                    buf_s       = BUF_ZERO;
                    cnt_s       = 3'd0;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = {TW{1'b0}};
                    state_s     = ST_SETKEY;
                end else begin
                    state_s = ST_UNLOCK;
                end
            end
            ST_ERROR: begin
                if (tmr_expired_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            ST_ALARM: begin
                if (tmr_expired_s) begin
                    err_s   = 2'd0;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ALARM;
                end
            end
            default: begin
                state_s = ST_WAIT;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r  <= ST_WAIT;
            buf_r    <= BUF_ZERO;
            cnt_r    <= 3'd0;
            err_r    <= 2'd0;
            key_r    <= DEFAULT_KEY;
            unlock_r <= 1'b0;
            alarm_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            buf_r    <= buf_s;
            cnt_r    <= cnt_s;
            err_r    <= err_s;
            key_r    <= key_s;
            unlock_r <= (state_s == ST_UNLOCK);
            alarm_r  <= (state_s == ST_ALARM);
        end
    end

    assign STATE    = state_r;
    assign CODE_BUF = buf_r;
    assign DIG_CNT  = cnt_r;
    assign ERR_CNT  = err_r;
    assign UNLOCK   = unlock_r;
    assign ALARM    = alarm_r;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed self-checking bench for lock_ctrl with hand-computed expectations.
module tb_lock_ctrl;

    logic        CLK;
    logic        RESET;
    logic        TICK_1MS;
    logic        DIG_VALID;
    logic [3:0]  DIG;
    logic        BTN_OK;
    logic        BTN_BKSP;
    logic        BTN_ADMIN;
    logic [2:0]  STATE;
    logic [15:0] CODE_BUF;
    logic [2:0]  DIG_CNT;
    logic [1:0]  ERR_CNT;
    logic        UNLOCK;
    logic        ALARM;

    int checks = 0;
    int fails  = 0;

    lock_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .TICK_1MS  (TICK_1MS),
        .DIG_VALID (DIG_VALID),
        .DIG       (DIG),
        .BTN_OK    (BTN_OK),
        .BTN_BKSP  (BTN_BKSP),
        .BTN_ADMIN (BTN_ADMIN),
        .STATE     (STATE),
        .CODE_BUF  (CODE_BUF),
        .DIG_CNT   (DIG_CNT),
        .ERR_CNT   (ERR_CNT),
        .UNLOCK    (UNLOCK),
        .ALARM     (ALARM)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One-cycle pulse of any combination; returns #1 after the sampling edge.
    task automatic pulse(input logic ok, input logic bk, input logic dv, input logic adm,
                         input logic tk, input logic [3:0] d);
        @(posedge CLK); #1;
        BTN_OK = ok; BTN_BKSP = bk; DIG_VALID = dv; BTN_ADMIN = adm; TICK_1MS = tk; DIG = d;
        @(posedge CLK); #1;
        BTN_OK = 1'b0; BTN_BKSP = 1'b0; DIG_VALID = 1'b0; BTN_ADMIN = 1'b0; TICK_1MS = 1'b0; DIG = 4'd0;
    endtask

    task automatic digit(input logic [3:0] d);  pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d);    endtask
    task automatic ok();                        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0); endtask
    task automatic bksp();                      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); endtask
    task automatic admin();                     pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) digit(c[4*i +: 4]);
    endtask

    // Asynchronous reset asserted between clock edges, released between edges.
    task automatic do_reset();
        @(posedge CLK); #4;
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge CLK); #4;
        RESET = 1'b1;
        #1;
        if (STATE !== 3'd0)      begin $display("FAIL rst_state got=%0d exp=0", STATE); fails++; end checks++;
        if (CODE_BUF !== 16'h0)  begin $display("FAIL rst_buf got=%h exp=0000", CODE_BUF); fails++; end checks++;
        if (DIG_CNT !== 3'd0)    begin $display("FAIL rst_cnt got=%0d exp=0", DIG_CNT); fails++; end checks++;
        if (ERR_CNT !== 2'd0)    begin $display("FAIL rst_err got=%0d exp=0", ERR_CNT); fails++; end checks++;
        if (UNLOCK !== 1'b0)     begin $display("FAIL rst_unlock got=%b exp=0", UNLOCK); fails++; end checks++;
        if (ALARM !== 1'b0)      begin $display("FAIL rst_alarm got=%b exp=0", ALARM); fails++; end checks++;
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_correct_code();
        digit(4'd1);
        if (STATE !== 3'd1)      begin $display("FAIL cc_input got=%0d exp=1", STATE); fails++; end checks++;
        digit(4'd2); digit(4'd3); digit(4'd4);
        if (CODE_BUF !== 16'h1234) begin $display("FAIL cc_buf got=%h exp=1234", CODE_BUF); fails++; end checks++;
        if (DIG_CNT !== 3'd4)    begin $display("FAIL cc_cnt got=%0d exp=4", DIG_CNT); fails++; end checks++;
        ok();
        if (STATE !== 3'd2)      begin $display("FAIL cc_unlock_state got=%0d exp=2", STATE); fails++; end checks++;
        if (UNLOCK !== 1'b1)     begin $display("FAIL cc_unlock got=%b exp=1", UNLOCK); fails++; end checks++;
        if (CODE_BUF !== 16'h0 || DIG_CNT !== 3'd0) begin $display("FAIL cc_clear got=%h/%0d exp=0000/0", CODE_BUF, DIG_CNT); fails++; end checks++;
        ticks(4999);
        if (STATE !== 3'd2)      begin $display("FAIL cc_hold got=%0d exp=2", STATE); fails++; end checks++;
        ticks(1);
        if (STATE !== 3'd0 || UNLOCK !== 1'b0) begin $display("FAIL cc_expire got=%0d/%b exp=0/0", STATE, UNLOCK); fails++; end checks++;
    endtask

    task automatic test_wrong_codes();
        // First attempt: OK coincides with a tick, which must not count.
        enter_code(16'h1235);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        if (STATE !== 3'd3 || ERR_CNT !== 2'd1) begin $display("FAIL wc_err1 got=%0d/%0d exp=3/1", STATE, ERR_CNT); fails++; end checks++;
        digit(4'd7);
        if (DIG_CNT !== 3'd0 || STATE !== 3'd3) begin $display("FAIL wc_err_ignore got=%0d/%0d exp=0/3", DIG_CNT, STATE); fails++; end checks++;
        ticks(999);
        if (STATE !== 3'd3)      begin $display("FAIL wc_err_hold got=%0d exp=3", STATE); fails++; end checks++;
        ticks(1);
        if (STATE !== 3'd0)      begin $display("FAIL wc_err_expire got=%0d exp=0", STATE); fails++; end checks++;
        enter_code(16'h1235); ok();
        if (STATE !== 3'd3 || ERR_CNT !== 2'd2) begin $display("FAIL wc_err2 got=%0d/%0d exp=3/2", STATE, ERR_CNT); fails++; end checks++;
        ticks(1000);
        enter_code(16'h1235); ok();
        if (STATE !== 3'd4 || ALARM !== 1'b1 || ERR_CNT !== 2'd3) begin $display("FAIL wc_alarm got=%0d/%b/%0d exp=4/1/3", STATE, ALARM, ERR_CNT); fails++; end checks++;
        digit(4'd1); ok(); admin(); bksp();
        if (STATE !== 3'd4 || DIG_CNT !== 3'd0) begin $display("FAIL wc_alarm_ignore got=%0d/%0d exp=4/0", STATE, DIG_CNT); fails++; end checks++;
        ticks(9999);
        if (STATE !== 3'd4)      begin $display("FAIL wc_alarm_hold got=%0d exp=4", STATE); fails++; end checks++;
        ticks(1);
        if (STATE !== 3'd0 || ERR_CNT !== 2'd0 || ALARM !== 1'b0) begin $display("FAIL wc_alarm_expire got=%0d/%0d/%b exp=0/0/0", STATE, ERR_CNT, ALARM); fails++; end checks++;
    endtask

    task automatic test_backspace();
        enter_code(16'h1111); ok();
        ticks(1000);
        digit(4'd1); digit(4'd2); digit(4'd9); bksp();
        if (CODE_BUF !== 16'h0012 || DIG_CNT !== 3'd2) begin $display("FAIL bs_shift got=%h/%0d exp=0012/2", CODE_BUF, DIG_CNT); fails++; end checks++;
        digit(4'd3); digit(4'd4); digit(4'd7);
        if (CODE_BUF !== 16'h1234 || DIG_CNT !== 3'd4) begin $display("FAIL bs_full got=%h/%0d exp=1234/4", CODE_BUF, DIG_CNT); fails++; end checks++;
        ok();
        if (STATE !== 3'd2 || ERR_CNT !== 2'd0) begin $display("FAIL bs_unlock got=%0d/%0d exp=2/0", STATE, ERR_CNT); fails++; end checks++;
        do_reset();
        digit(4'd5); bksp(); bksp();
        if (STATE !== 3'd1 || DIG_CNT !== 3'd0 || CODE_BUF !== 16'h0) begin $display("FAIL bs_empty got=%0d/%0d/%h exp=1/0/0000", STATE, DIG_CNT, CODE_BUF); fails++; end checks++;
        digit(4'd1); digit(4'd2); digit(4'd3); ok();
        if (STATE !== 3'd1 || DIG_CNT !== 3'd3 || CODE_BUF !== 16'h0123) begin $display("FAIL bs_partial_ok got=%0d/%0d/%h exp=1/3/0123", STATE, DIG_CNT, CODE_BUF); fails++; end checks++;
        digit(4'd12);
        if (DIG_CNT !== 3'd3)    begin $display("FAIL bs_bad_digit got=%0d exp=3", DIG_CNT); fails++; end checks++;
        do_reset();
    endtask

    task automatic test_same_cycle();
        digit(4'd1);
        pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
        if (DIG_CNT !== 3'd0 || CODE_BUF !== 16'h0) begin $display("FAIL sc_bksp_dig got=%0d/%h exp=0/0000", DIG_CNT, CODE_BUF); fails++; end checks++;
        enter_code(16'h1234);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        if (STATE !== 3'd2 || DIG_CNT !== 3'd0 || CODE_BUF !== 16'h0) begin $display("FAIL sc_ok_dig got=%0d/%0d/%h exp=2/0/0000", STATE, DIG_CNT, CODE_BUF); fails++; end checks++;
        do_reset();
    endtask

    task automatic test_key_change();
        enter_code(16'h1234); ok(); admin();
        if (STATE !== 3'd5 || UNLOCK !== 1'b0) begin $display("FAIL kc_setkey got=%0d/%b exp=5/0", STATE, UNLOCK); fails++; end checks++;
        ticks(5001);
        if (STATE !== 3'd5)      begin $display("FAIL kc_timer_stop got=%0d exp=5", STATE); fails++; end checks++;
        enter_code(16'h9876); ok();
        if (STATE !== 3'd0 || CODE_BUF !== 16'h0) begin $display("FAIL kc_store got=%0d/%h exp=0/0000", STATE, CODE_BUF); fails++; end checks++;
        enter_code(16'h1234); ok();
        if (STATE !== 3'd3 || ERR_CNT !== 2'd1) begin $display("FAIL kc_old_key got=%0d/%0d exp=3/1", STATE, ERR_CNT); fails++; end checks++;
        ticks(1000);
        enter_code(16'h9876); ok();
        if (STATE !== 3'd2 || ERR_CNT !== 2'd0) begin $display("FAIL kc_new_key got=%0d/%0d exp=2/0", STATE, ERR_CNT); fails++; end checks++;
        admin(); digit(4'd1); digit(4'd1); admin();
        if (STATE !== 3'd0 || DIG_CNT !== 3'd0) begin $display("FAIL kc_abort got=%0d/%0d exp=0/0", STATE, DIG_CNT); fails++; end checks++;
        enter_code(16'h9876); ok();
        if (STATE !== 3'd2)      begin $display("FAIL kc_abort_keep got=%0d exp=2", STATE); fails++; end checks++;
    endtask

    task automatic test_reset_mid();
        // Reset during SETKEY entry with a changed key.
        admin(); digit(4'd5); digit(4'd5);
        @(posedge CLK); #4;
        RESET = 1'b1;
        #1;
        if (STATE !== 3'd0 || DIG_CNT !== 3'd0 || CODE_BUF !== 16'h0) begin $display("FAIL rm_setkey got=%0d/%0d/%h exp=0/0/0000", STATE, DIG_CNT, CODE_BUF); fails++; end checks++;
        #1;
        RESET = 1'b0;
        enter_code(16'h1234); ok();
        if (STATE !== 3'd2)      begin $display("FAIL rm_key_revert got=%0d exp=2", STATE); fails++; end checks++;
        do_reset();
        // Reset during ALARM.
        enter_code(16'h0000); ok(); ticks(1000);
        enter_code(16'h0000); ok(); ticks(1000);
        enter_code(16'h0000); ok();
        if (ALARM !== 1'b1)      begin $display("FAIL rm_alarm_entry got=%b exp=1", ALARM); fails++; end checks++;
        @(posedge CLK); #4;
        RESET = 1'b1;
        #1;
        if (STATE !== 3'd0 || ALARM !== 1'b0 || ERR_CNT !== 2'd0) begin $display("FAIL rm_alarm got=%0d/%b/%0d exp=0/0/0", STATE, ALARM, ERR_CNT); fails++; end checks++;
        #1;
        RESET = 1'b0;
        enter_code(16'h1234); ok();
        if (STATE !== 3'd2 || UNLOCK !== 1'b1) begin $display("FAIL rm_after got=%0d/%b exp=2/1", STATE, UNLOCK); fails++; end checks++;
    endtask

    initial begin
        RESET = 1'b1; TICK_1MS = 1'b0; DIG_VALID = 1'b0; DIG = 4'd0;
        BTN_OK = 1'b0; BTN_BKSP = 1'b0; BTN_ADMIN = 1'b0;
        #12;
        RESET = 1'b0;
        test_reset();
        test_correct_code();
        test_wrong_codes();
        test_backspace();
        test_same_cycle();
        test_key_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
Sequencing controller for the password-lock system. It takes already-debounced single-cycle pulses for digit entry and for the OK/BACKSPACE/ADMIN buttons, plus a 1 ms tick. It runs the lock state machine: code entry, compare against the stored key, error counting, alarm lockout, unlock hold and key change. Outputs drive the display/LED formatter; the block does no debouncing and no segment encoding.

Parameters:
NDIG, 4, digits per code (4 bits per digit)
MAX_ERR, 3, consecutive wrong attempts that trigger ALARM
UNLOCK_MS, 5000, unlock hold time in 1 ms ticks
ERROR_MS, 1000, error indication time in ticks
ALARM_MS, 10000, alarm lockout time in ticks
DEFAULT_KEY, 16'h1234, key value loaded at reset

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
TICK_1MS  in  1  one-cycle pulse every 1 ms
DIG_VALID  in  1  one-cycle pulse: DIG holds a new digit
DIG  in  4  digit value 0-9; values above 9 are ignored
BTN_OK  in  1  one-cycle pulse
BTN_BKSP  in  1  one-cycle pulse
BTN_ADMIN  in  1  one-cycle pulse
STATE  out  3  current state encoding
CODE_BUF  out  4*NDIG  entered digits; newest digit in bits [3:0]
DIG_CNT  out  3  number of digits entered, 0..NDIG
ERR_CNT  out  2  consecutive error count
UNLOCK  out  1  high while in UNLOCK
ALARM  out  1  high while in ALARM

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - STATE=WAIT; CODE_BUF=0; DIG_CNT=0; ERR_CNT=0; UNLOCK=0; ALARM=0.
  - Stored key = DEFAULT_KEY; timer=0.
- All outputs are registered. A pulse on cycle N is reflected in outputs on cycle N+1.
- States: WAIT=0, INPUT=1, UNLOCK=2, ERROR=3, ALARM=4, SETKEY=5. Unused codes go to WAIT.
- Same-cycle input priority: BTN_OK > BTN_BKSP > DIG_VALID > BTN_ADMIN. Lower-priority pulses in that cycle are dropped.
- Digit entry (WAIT, INPUT, SETKEY):
  - Valid digit with DIG_CNT<NDIG: CODE_BUF={CODE_BUF[4*NDIG-5:0],DIG}; DIG_CNT+1.
  - In WAIT, a valid digit also moves the state to INPUT.
  - DIG_CNT==NDIG: the digit is ignored.
- Backspace (INPUT, SETKEY):
  - DIG_CNT>0: CODE_BUF shifts right 4 bits with zero fill; DIG_CNT-1.
  - DIG_CNT==0: ignored. INPUT does not fall back to WAIT.
- OK in INPUT:
  - DIG_CNT<NDIG: ignored.
  - Full entry, CODE_BUF==key: go to UNLOCK; ERR_CNT=0.
  - Full entry, mismatch: ERR_CNT+1, saturating at MAX_ERR.
    - New count == MAX_ERR: go to ALARM.
    - Otherwise: go to ERROR.
  - Every evaluated OK clears CODE_BUF and DIG_CNT and loads the timer.
- Timed states:
  - ERROR: after ERROR_MS ticks, go to WAIT.
  - UNLOCK: after UNLOCK_MS ticks, go to WAIT.
  - ALARM: after ALARM_MS ticks, go to WAIT with ERR_CNT=0.
- Timer mechanics:
  - The timer loads on state entry and decrements only on TICK_1MS.
  - Expiry happens in the cycle the count reaches 0. A tick coinciding with entry is not counted.
- Ignored inputs: ERROR and ALARM ignore every button and digit. In ALARM, only RESET or timeout exits.
- ADMIN:
  - In UNLOCK: go to SETKEY; clear CODE_BUF and DIG_CNT; stop the timer.
  - In all other states: ignored.
- SETKEY:
  - OK with DIG_CNT==NDIG: key=CODE_BUF; clear the buffer; go to WAIT.
  - OK with a partial entry: ignored.
  - ADMIN in SETKEY: abort to WAIT, key unchanged.
- ERR_CNT is cleared only by a correct code, by ALARM expiry, or by RESET.
- RESET mid-operation (any state, including SETKEY mid-entry): full reset values; key returns to DEFAULT_KEY.

Decomposition:
- Shared package lock_pkg holds:
  - state encodings WAIT..SETKEY;
  - the button index constants BTN_ADMIN=0, BTN_OK=1, BTN_BACKSPACE=2;
  - DEFAULT_KEY.
- One sub-module, lock_ms_timer:
  - loadable down-counter with width sized for the largest of UNLOCK_MS/ERROR_MS/ALARM_MS;
  - inputs load/value/tick; output expired pulse.
- The FSM, digit buffer, key register and error counter live in lock_ctrl.

Test Plan:
- Correct code: reset; digits 1,2,3,4; OK -> STATE=UNLOCK, UNLOCK=1, ERR_CNT=0. After 5000 ticks -> STATE=WAIT, UNLOCK=0.
- Wrong codes: 1,2,3,5 + OK three times -> ERR_CNT 1, 2 with ERROR (back to WAIT after 1000 ticks), then ALARM=1. Digits and OK are ignored during ALARM. After 10000 ticks: WAIT, ERR_CNT=0.
- Backspace and limits:
  - 1,2,9 then BKSP -> CODE_BUF=16'h0012, DIG_CNT=2;
  - then 3,4,7 -> CODE_BUF=16'h1234, DIG_CNT=4 (7 dropped);
  - OK -> UNLOCK.
  - BKSP at DIG_CNT=0 leaves 0. OK with 3 digits is ignored.
- Same-cycle pulses: OK+DIG_VALID together with a full correct buffer -> UNLOCK and the digit is dropped.
- Key change: unlock; ADMIN -> SETKEY; 9,8,7,6 + OK -> WAIT. Then 1,2,3,4 + OK -> ERROR; 9,8,7,6 + OK -> UNLOCK.
- Reset mid-operation: assert RESET asynchronously during ALARM and during SETKEY entry -> all outputs at reset values within the same cycle; key reverts, so 1,2,3,4 unlocks.
